// File: rtl/adc_serial_tx.sv
`default_nettype none
// ============================================================================
// adc_serial_tx
//   Serial ADC emulator: after chip select falls, shifts out a frame of
//   LEAD_ZEROS zeros followed by DATA_BITS sample bits, MSB first.
// Revision: 1.0
// ============================================================================
module adc_serial_tx #(
  parameter int DATA_BITS  = 12,
  parameter int LEAD_ZEROS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs_in,
  input  logic [DATA_BITS-1:0] sample_in,
  input  logic                 sample_valid_in,
  input  logic                 error_inject_in,
  output logic                 data_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 abort_out
);

  localparam int c_FRAME_LEN = LEAD_ZEROS + DATA_BITS;
  localparam int c_CNT_W     = $clog2(c_FRAME_LEN);

  localparam logic [c_CNT_W-1:0] c_LAST       = c_CNT_W'(c_FRAME_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_LEAD_LAST  = c_CNT_W'(LEAD_ZEROS - 1);
  localparam logic [c_CNT_W-1:0] c_DATA_FIRST = c_CNT_W'(LEAD_ZEROS);
  localparam logic [c_CNT_W-1:0] c_ONE        = c_CNT_W'(1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LEAD  = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_TRAIL = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 r_cs_q;
  logic                 r_armed;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_err;
  logic                 r_frame_err;
  logic [DATA_BITS-1:0] r_shift;
  logic [c_CNT_W-1:0]   r_bit_cnt;
  logic                 r_data;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_abort;

  logic                 w_start;
  logic                 w_in_frame;
  logic [c_CNT_W-1:0]   w_cnt_inc;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic                 w_ferr_nxt;
  logic                 w_data_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_abort_nxt;

  // r_armed blocks a frame when cs is already low coming out of reset.
  assign w_start    = r_armed && r_cs_q && !cs_in &&
                      ((r_state == c_IDLE) || (r_state == c_TRAIL));
  assign w_in_frame = (r_state == c_LEAD) || (r_state == c_DATA);
  assign w_cnt_inc  = r_bit_cnt + c_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_cs_q      <= 1'b1;
      r_armed     <= 1'b0;
      r_hold      <= '0;
      r_err       <= 1'b0;
      r_frame_err <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_data      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cs_q      <= cs_in;
      r_armed     <= r_armed | cs_in;
      if (sample_valid_in) begin
        r_hold <= sample_in;
      end
      if (w_start) begin
        r_err <= 1'b0;
      end else if (error_inject_in) begin
        r_err <= 1'b1;
      end
      r_frame_err <= w_ferr_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_data      <= w_data_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_abort     <= w_abort_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_start) begin
          w_state_nxt = c_LEAD;
        end
      end
      c_LEAD: begin
        if (cs_in) begin
          w_state_nxt = c_IDLE;
        end else if (r_bit_cnt == c_LEAD_LAST) begin
          w_state_nxt = c_DATA;
        end
      end
      c_DATA: begin
        if (cs_in) begin
          w_state_nxt = c_IDLE;
        end else if (r_bit_cnt == c_LAST) begin
          w_state_nxt = c_TRAIL;
        end
      end
      c_TRAIL: begin
        if (cs_in) begin
          w_state_nxt = c_IDLE;
        end else if (w_start) begin
          w_state_nxt = c_LEAD;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_bit_cnt;
    w_ferr_nxt  = r_frame_err;
    w_data_nxt  = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    if (w_start) begin
      // A load on the start edge bypasses the holding register.
      w_shift_nxt = sample_valid_in ? sample_in : r_hold;
      w_ferr_nxt  = r_err | error_inject_in;
      w_cnt_nxt   = '0;
      w_busy_nxt  = 1'b1;
      w_data_nxt  = (LEAD_ZEROS == 1) && (r_err | error_inject_in);
    end else if (w_in_frame) begin
      if (cs_in) begin
        w_abort_nxt = 1'b1;
      end else if (r_bit_cnt == c_LAST) begin
        w_done_nxt = 1'b1;
      end else begin
        w_cnt_nxt  = w_cnt_inc;
        w_busy_nxt = 1'b1;
        if (w_cnt_inc >= c_DATA_FIRST) begin
          w_data_nxt  = r_shift[DATA_BITS-1];
          w_shift_nxt = r_shift << 1;
        end else begin
          w_data_nxt  = r_frame_err && (w_cnt_inc == c_LEAD_LAST);
        end
      end
    end
  end

  assign data_out  = r_data;
  assign busy_out  = r_busy;
  assign done_out  = r_done;
  assign abort_out = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_tx.sv
`default_nettype none
// Bench for adc_serial_tx: table vectors, hand-written corner sequences and
// randomized frames compared against a frame-level reference model.
module tb_adc_serial_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_in;
  logic [11:0] sample_in;
  logic        sample_valid_in;
  logic        error_inject_in;
  logic        data_out;
  logic        busy_out;
  logic        done_out;
  logic        abort_out;

  int checks   = 0;
  int failures = 0;

  logic [11:0] m_hold;
  bit          m_err;

  adc_serial_tx #(.DATA_BITS(12), .LEAD_ZEROS(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cs_in           (cs_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .error_inject_in (error_inject_in),
    .data_out        (data_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .abort_out       (abort_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_load;
    logic [11:0] val;
    bit          bypass;
    bit          inject;
    logic [15:0] exp_frame;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A frame is simply the leading-zero field (last zero flipped on error) above the sample.
  function automatic logic [15:0] model_frame(input logic [11:0] v, input bit e);
    logic [15:0] f;
    f = {4'b0000, v};
    if (e) f = f | 16'h1000;
    return f;
  endfunction

  task automatic load(input logic [11:0] v);
    @(negedge clk);
    sample_valid_in = 1'b1;
    sample_in = v;
    @(negedge clk);
    sample_valid_in = 1'b0;
    m_hold = v;
  endtask

  task automatic inject();
    @(negedge clk);
    error_inject_in = 1'b1;
    @(negedge clk);
    error_inject_in = 1'b0;
    m_err = 1'b1;
  endtask

  task automatic do_frame(input bit bypass, input logic [11:0] bval, input int load_at,
                          input logic [11:0] lval, input logic [15:0] exp_frame,
                          input int trail, input string tag);
    logic [15:0] got;
    int busy_cnt;
    int early_done;
    int trail_bad;
    got = '0;
    busy_cnt = 0;
    early_done = 0;
    trail_bad = 0;
    @(negedge clk);
    cs_in = 1'b1;
    @(negedge clk);
    cs_in = 1'b0;
    if (bypass) begin
      sample_valid_in = 1'b1;
      sample_in = bval;
      m_hold = bval;
    end
    m_err = 1'b0;
    @(posedge clk);
    #1;
    sample_valid_in = 1'b0;
    got[15] = data_out;
    busy_cnt += int'(busy_out);
    early_done += int'(done_out);
    for (int k = 1; k < 16; k++) begin
      if (load_at == k - 1) begin
        sample_valid_in = 1'b1;
        sample_in = lval;
        m_hold = lval;
      end
      @(posedge clk);
      #1;
      sample_valid_in = 1'b0;
      got[15-k] = data_out;
      busy_cnt += int'(busy_out);
      early_done += int'(done_out);
    end
    chk({tag, "_frame"}, 32'(got), 32'(exp_frame));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
    chk({tag, "_no_early_done"}, 32'(early_done), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {29'd0, done_out, busy_out, data_out}, 32'b100);
    @(posedge clk);
    #1;
    chk({tag, "_done_clear"}, {30'd0, done_out, abort_out}, 32'd0);
    for (int t = 0; t < trail; t++) begin
      @(posedge clk);
      #1;
      trail_bad += int'(data_out | busy_out | done_out);
    end
    if (trail > 0) chk({tag, "_trail_quiet"}, 32'(trail_bad), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int seen;
    logic [15:0] got;
    vecs[0] = '{1'b1, 12'hA5C, 1'b0, 1'b0, 16'h0A5C};
    vecs[1] = '{1'b1, 12'h000, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 12'hFFF, 1'b0, 1'b0, 16'h0FFF};
    vecs[3] = '{1'b0, 12'h000, 1'b0, 1'b0, 16'h0FFF};
    vecs[4] = '{1'b1, 12'h555, 1'b0, 1'b1, 16'h1555};
    vecs[5] = '{1'b0, 12'h000, 1'b0, 1'b0, 16'h0555};
    vecs[6] = '{1'b1, 12'h123, 1'b1, 1'b0, 16'h0123};

    m_hold = '0;
    m_err = 1'b0;
    rst_n = 1'b0;
    cs_in = 1'b0;
    sample_in = '0;
    sample_valid_in = 1'b0;
    error_inject_in = 1'b0;
    #1;
    chk("reset_outputs", {28'd0, data_out, busy_out, done_out, abort_out}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen += int'(busy_out | data_out | done_out);
    end
    chk("no_frame_cs_low_from_reset", 32'(seen), 32'd0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].inject) inject();
      if (vecs[i].do_load && !vecs[i].bypass) load(vecs[i].val);
      do_frame(vecs[i].bypass, vecs[i].val, -1, 12'h000, vecs[i].exp_frame, 2,
               $sformatf("vec%0d", i));
    end

    // In-flight load during bit 9 must wait for the next frame.
    do_frame(1'b0, 12'h000, 9, 12'h456, 16'h0123, 0, "inflight_cur");
    do_frame(1'b0, 12'h000, -1, 12'h000, 16'h0456, 0, "inflight_next");

    // Abort at frame bit 7.
    load(12'h9C3);
    @(negedge clk);
    cs_in = 1'b1;
    @(negedge clk);
    cs_in = 1'b0;
    got = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      got[15-k] = data_out;
    end
    chk("abort_prefix", 32'(got[15:8]), 32'h09);
    @(negedge clk);
    cs_in = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_pulse", {28'd0, abort_out, done_out, busy_out, data_out}, 32'b1000);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      seen += int'(abort_out | done_out | busy_out | data_out);
    end
    chk("abort_aftermath_quiet", 32'(seen), 32'd0);
    do_frame(1'b0, 12'h000, -1, 12'h000, 16'h09C3, 1, "after_abort");

    // Reset mid-frame, with an error request pending that reset must clear.
    load(12'h7E1);
    @(negedge clk);
    cs_in = 1'b1;
    @(negedge clk);
    cs_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    error_inject_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    error_inject_in = 1'b0;
    chk("midframe_busy", 32'(busy_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {28'd0, data_out, busy_out, done_out, abort_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_hold = '0;
    m_err = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen += int'(busy_out | done_out | abort_out | data_out);
    end
    chk("post_reset_quiet", 32'(seen), 32'd0);
    do_frame(1'b0, 12'h000, -1, 12'h000, 16'h0000, 0, "post_reset_hold");

    // Randomized frames against the frame-level model.
    for (int i = 0; i < 30; i++) begin
      int r;
      bit byp;
      logic [11:0] bv;
      int la;
      logic [11:0] lv;
      r = int'($urandom);
      if (r % 3 == 0) load(12'($urandom));
      if (r % 5 == 0) inject();
      byp = (($urandom % 4) == 0);
      bv = 12'($urandom);
      la = (($urandom % 3) == 0) ? int'($urandom_range(0, 14)) : -1;
      lv = 12'($urandom);
      do_frame(byp, bv, la, lv, model_frame(byp ? bv : m_hold, m_err),
               int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
